// File: rtl/hamming_8_4_stream_encoder.sv
// ---------------------------------------------------------------------------
// hamming_8_4_stream_encoder
//
// Transmit-side extended Hamming(8,4) encoder. Accepts bytes over a
// valid/ready handshake, splits each byte into two nibbles and streams one
// SECDED codeword per nibble over a second valid/ready handshake, using the
// bit layout the companion corrector expects.
//
// Codeword layout for nibble d[3:0]:
//   bit7=d3 bit6=d2 bit5=d1 bit4=p4 bit3=d0 bit2=p2 bit1=p1 bit0=overall
//   p1=d0^d1^d3, p2=d0^d2^d3, p4=d1^d2^d3, overall = ^bits[7:1]
//   The XOR of the indices of all set bits is zero and overall parity is even.
//
// Parameters:
//   LSN_FIRST  1 = byte[3:0] sent first, 0 = byte[7:4] sent first
//   COUNT_W    width of the transferred-codeword counter
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous reset, active-high, beats every handshake
//   in_data    data byte
//   in_valid   source has a byte
//   in_ready   encoder takes the byte this cycle (combinational on out_ready)
//   out_data   registered codeword
//   out_valid  codeword valid
//   out_ready  sink takes the codeword this cycle
//   out_last   codeword carries the second nibble of its byte
//   cw_count   codewords transferred since reset, wraps
//   inj_mask   (HAMMING_ERR_INJECT_EN only) XOR mask applied to each codeword
//              at the cycle it is loaded into out_data
//
// Build option:
//   HAMMING_ERR_INJECT_EN  adds inj_mask for error injection into the channel.
//                          Undefined: no extra port, codewords always clean.
// ---------------------------------------------------------------------------
module hamming_8_4_stream_encoder #(
    parameter int unsigned LSN_FIRST = 1,
    parameter int unsigned COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic [COUNT_W-1:0] cw_count
`ifdef HAMMING_ERR_INJECT_EN
    ,
    input  logic [7:0]         inj_mask
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEND_A = 2'd1;
    localparam logic [1:0] SEND_B = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [7:0]         hold_q, hold_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic [7:0] mask;
    logic       accept;
    logic       xfer;
    logic [3:0] first_nib_in;
    logic [3:0] second_nib_hold;

`ifdef HAMMING_ERR_INJECT_EN
    assign mask = inj_mask;
`else
    assign mask = 8'h00;
`endif

    // Extended Hamming encode; data sits at the non-power-of-two indices so
    // the corrector's syndrome directly names the flipped bit.
    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [7:0] c;
        c    = 8'h00;
        c[3] = d[0];
        c[5] = d[1];
        c[6] = d[2];
        c[7] = d[3];
        c[1] = d[0] ^ d[1] ^ d[3];
        c[2] = d[0] ^ d[2] ^ d[3];
        c[4] = d[1] ^ d[2] ^ d[3];
        c[0] = ^c[7:1];
        return c;
    endfunction

    assign first_nib_in    = (LSN_FIRST != 0) ? in_data[3:0] : in_data[7:4];
    assign second_nib_hold = (LSN_FIRST != 0) ? hold_q[7:4]  : hold_q[3:0];

    // A new byte may enter in the SEND_B cycle that retires the previous
    // byte's last codeword, giving back-to-back throughput with no bubble.
    assign in_ready = (state_q == IDLE) | ((state_q == SEND_B) & out_ready);
    assign accept   = in_valid & in_ready;
    assign xfer     = valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        count_d = count_q + {{(COUNT_W-1){1'b0}}, xfer};

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    hold_d  = in_data;
                    data_d  = encode(first_nib_in) ^ mask;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    state_d = SEND_A;
                end
            end
            SEND_A: begin
                if (out_ready) begin
                    data_d  = encode(second_nib_hold) ^ mask;
                    last_d  = 1'b1;
                    state_d = SEND_B;
                end
            end
            SEND_B: begin
                if (out_ready) begin
                    if (in_valid) begin
                        hold_d  = in_data;
                        data_d  = encode(first_nib_in) ^ mask;
                        valid_d = 1'b1;
                        last_d  = 1'b0;
                        state_d = SEND_A;
                    end else begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign cw_count  = count_q;

endmodule

// File: tb/tb_hamming_8_4_stream_encoder.sv
// ---------------------------------------------------------------------------
// tb_hamming_8_4_stream_encoder
//
// Directed bench for hamming_8_4_stream_encoder. A small counter width is used
// so the codeword counter wraps during the run. Expected codewords come from
// a search for the unique byte with the right data bits, even parity and zero
// index-XOR; a corrector model checks every transferred codeword.
// Define HAMMING_ERR_INJECT_EN to also exercise the inj_mask port.
// ---------------------------------------------------------------------------
module tb_hamming_8_4_stream_encoder;

    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [CW-1:0] cw_count;
    logic [7:0]    inj_mask;

    hamming_8_4_stream_encoder #(
        .LSN_FIRST (1),
        .COUNT_W   (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .cw_count  (cw_count)
`ifdef HAMMING_ERR_INJECT_EN
        ,
        .inj_mask  (inj_mask)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] cw;
        logic       last;
        logic [3:0] nib;
        logic [7:0] mask;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] cnt_model = '0;
    logic [7:0]    pend_byte = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] idx_xor(input logic [7:0] c);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 1; i < 8; i++) if (c[i]) s = s ^ i[2:0];
        return s;
    endfunction

    // Reference codeword found by search rather than by parity equations.
    function automatic logic [7:0] ref_cw(input logic [3:0] n);
        logic [7:0] c;
        for (int v = 0; v < 256; v++) begin
            c = v[7:0];
            if ({c[7], c[6], c[5], c[3]} == n && (^c) == 1'b0 && idx_xor(c) == 3'd0)
                return c;
        end
        return 8'hxx;
    endfunction

    // SECDED corrector model.
    task automatic corr(input logic [7:0] c, output logic [7:0] fixed,
                        output logic single, output logic dbl);
        logic [2:0] syn;
        syn    = idx_xor(c);
        fixed  = c;
        single = 1'b0;
        dbl    = 1'b0;
        if (syn != 3'd0) begin
            if (^c) begin
                fixed[syn] = ~fixed[syn];
                single     = 1'b1;
            end else begin
                dbl = 1'b1;
            end
        end else if (^c) begin
            fixed[0] = ~fixed[0];
            single   = 1'b1;
        end
    endtask

    function automatic exp_t mk(input logic [3:0] n, input logic last, input logic [7:0] m);
        exp_t e;
        e.cw   = ref_cw(n) ^ m;
        e.last = last;
        e.nib  = n;
        e.mask = m;
        return e;
    endfunction

    // One clock: score handshakes just before the rising edge, return #1 after it.
    task automatic step(output bit acc);
        exp_t       e;
        logic [7:0] fixed;
        logic       s;
        logic       d;
        acc = 1'b0;
        @(negedge clk);
        if (rst) begin
            sb.delete();
            cnt_model = '0;
        end else begin
            chk("cw_count", cw_count, cnt_model);
            if (out_valid && out_ready) begin
                chk("sb_has_entry", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e.cw);
                    chk("out_last", out_last, e.last);
                    corr(out_data, fixed, s, d);
                    if ($countones(e.mask) < 2)
                        chk("corr_data", {fixed[7], fixed[6], fixed[5], fixed[3]}, e.nib);
                    chk("corr_single", s, $countones(e.mask) == 1);
                    chk("corr_double", d, $countones(e.mask) == 2);
                    // Second codeword is loaded on this same edge with today's mask.
                    if (!e.last) sb.push_back(mk(pend_byte[7:4], 1'b1, inj_mask));
                end
                cnt_model = cnt_model + 1'b1;
            end
            if (in_valid && in_ready) begin
                pend_byte = in_data;
                sb.push_back(mk(in_data[3:0], 1'b0, inj_mask));
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [7:0] ex_bytes [8] = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE};

    initial begin
        bit         acc;
        logic [7:0] fixed;
        logic       s;
        logic       d;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        inj_mask  = 8'h00;
        @(posedge clk);
        #1;
        step(acc);
        step(acc);
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_last", out_last, 0);
        chk("rst_cw_count", cw_count, 0);
        chk("rst_in_ready", in_ready, 1);

        // Single byte 0xA5.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        step(acc);
        chk("a5_accept", acc, 1);
        in_valid = 1'b0;
        chk("a5_cw0", out_data, 8'h5A);
        chk("a5_last0", out_last, 0);
        step(acc);
        chk("a5_cw1", out_data, 8'hA5);
        chk("a5_last1", out_last, 1);
        step(acc);
        chk("a5_idle_valid", out_valid, 0);
        chk("a5_count", cw_count, 2);
        chk("a5_idle_ready", in_ready, 1);

        // 0x00 then 0xFF back to back.
        in_valid = 1'b1;
        in_data  = 8'h00;
        step(acc);
        in_data = 8'hFF;
        chk("b2b_valid0", out_valid, 1);
        chk("b2b_cw0", out_data, 8'h00);
        step(acc);
        chk("b2b_valid1", out_valid, 1);
        chk("b2b_sendb_ready", in_ready, 1);
        step(acc);
        chk("b2b_accept_in_b", acc, 1);
        in_valid = 1'b0;
        chk("b2b_valid2", out_valid, 1);
        chk("b2b_cw2", out_data, 8'hFF);
        step(acc);
        chk("b2b_valid3", out_valid, 1);
        chk("b2b_cw3", out_data, 8'hFF);
        step(acc);
        chk("b2b_idle", out_valid, 0);

        // Backpressure on byte 0x01; in_data wiggles while held.
        in_valid  = 1'b1;
        in_data   = 8'h01;
        out_ready = 1'b0;
        step(acc);
        for (int i = 0; i < 5; i++) begin
            in_data = 8'($urandom_range(0, 255));
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 8'h0F);
            chk("bp_ready", in_ready, 0);
            step(acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step(acc);
        chk("bp_cw1", out_data, 8'h00);
        step(acc);
        chk("bp_done", out_valid, 0);

        // All sixteen nibbles, streamed back to back.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = ex_bytes[i];
            acc      = 1'b0;
            for (int k = 0; k < 8 && !acc; k++) step(acc);
            chk("ex_accept", acc, 1);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) step(acc);
        chk("ex_drained", sb.size(), 0);

        // Reset while SEND_A holds a codeword; rst beats out_ready.
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        out_ready = 1'b0;
        step(acc);
        in_valid  = 1'b0;
        chk("mid_valid", out_valid, 1);
        rst       = 1'b1;
        out_ready = 1'b1;
        step(acc);
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_count", cw_count, 0);
        chk("mid_rst_ready", in_ready, 1);
        for (int k = 0; k < 3; k++) begin
            step(acc);
            chk("mid_no_stale", out_valid, 0);
        end

`ifdef HAMMING_ERR_INJECT_EN
        // Single-bit injection on the first codeword of 0x05.
        in_valid = 1'b1;
        in_data  = 8'h05;
        inj_mask = 8'h08;
        step(acc);
        in_valid = 1'b0;
        inj_mask = 8'h00;
        chk("inj_cw", out_data, 8'h52);
        corr(out_data, fixed, s, d);
        chk("inj_fixed", fixed, 8'h5A);
        chk("inj_single", s, 1);
        step(acc);
        step(acc);
        chk("inj_drained", sb.size(), 0);
`else
        fixed = 8'h00;
        s     = 1'b0;
        d     = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
